// File: rtl/uni_arbiter.sv
// Two-master round-robin arbiter onto one uni request port; payload latched at grant, o_m_valid one cycle after.
// Backpressure: masters hold valid and payload until their one-cycle ready pulse, which follows i_m_ready by one cycle.
module uni_arbiter #(
    parameter int UNI_ADDR_WIDTH = 32,
    parameter int UNI_DATA_WIDTH = 128
) (
    input  logic                      i_clk,
    input  logic                      i_rst,

    input  logic                      i_s0_valid,
    input  logic                      i_s0_reqtyp,
    input  logic [UNI_ADDR_WIDTH-1:0] i_s0_addr,
    input  logic [1:0]                i_s0_size,
    input  logic                      i_s0_cachable,
    input  logic [UNI_DATA_WIDTH-1:0] i_s0_wdata,
    output logic                      o_s0_ready,
    output logic [UNI_DATA_WIDTH-1:0] o_s0_rdata,

    input  logic                      i_s1_valid,
    input  logic                      i_s1_reqtyp,
    input  logic [UNI_ADDR_WIDTH-1:0] i_s1_addr,
    input  logic [1:0]                i_s1_size,
    input  logic                      i_s1_cachable,
    input  logic [UNI_DATA_WIDTH-1:0] i_s1_wdata,
    output logic                      o_s1_ready,
    output logic [UNI_DATA_WIDTH-1:0] o_s1_rdata,

    output logic                      o_m_valid,
    output logic                      o_m_reqtyp,
    output logic [UNI_ADDR_WIDTH-1:0] o_m_addr,
    output logic [1:0]                o_m_size,
    output logic                      o_m_cachable,
    output logic [UNI_DATA_WIDTH-1:0] o_m_wdata,
    input  logic                      i_m_ready,
    input  logic [UNI_DATA_WIDTH-1:0] i_m_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                      reqtyp;
        logic [UNI_ADDR_WIDTH-1:0] addr;
        logic [1:0]                size;
        logic                      cachable;
        logic [UNI_DATA_WIDTH-1:0] wdata;
    } req_t;

    state_t                    state_q, state_d;
    logic                      gnt_q, gnt_d;
    logic                      rr_ptr_q, rr_ptr_d;
    req_t                      req_q, req_d;
    req_t                      s0_req, s1_req;
    logic                      pick;
    logic                      s0_ready_q, s0_ready_d;
    logic                      s1_ready_q, s1_ready_d;
    logic [UNI_DATA_WIDTH-1:0] s0_rdata_q, s0_rdata_d;
    logic [UNI_DATA_WIDTH-1:0] s1_rdata_q, s1_rdata_d;

    assign s0_req = {i_s0_reqtyp, i_s0_addr, i_s0_size, i_s0_cachable, i_s0_wdata};
    assign s1_req = {i_s1_reqtyp, i_s1_addr, i_s1_size, i_s1_cachable, i_s1_wdata};

    // A lone requester wins outright; contention goes to the round-robin pointer.
    assign pick = (i_s0_valid && i_s1_valid) ? rr_ptr_q : i_s1_valid;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        req_d      = req_q;
        s0_ready_d = 1'b0;
        s1_ready_d = 1'b0;
        s0_rdata_d = s0_rdata_q;
        s1_rdata_d = s1_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (i_s0_valid || i_s1_valid) begin
                    gnt_d   = pick;
                    req_d   = pick ? s1_req : s0_req;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_m_ready) begin
                    if (gnt_q) begin
                        s1_rdata_d = i_m_rdata;
                        s1_ready_d = 1'b1;
                    end else begin
                        s0_rdata_d = i_m_rdata;
                        s0_ready_d = 1'b1;
                    end
                    rr_ptr_d = ~gnt_q;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 1'b0;
            rr_ptr_q   <= 1'b0;
            req_q      <= '0;
            s0_ready_q <= 1'b0;
            s1_ready_q <= 1'b0;
            s0_rdata_q <= '0;
            s1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            req_q      <= req_d;
            s0_ready_q <= s0_ready_d;
            s1_ready_q <= s1_ready_d;
            s0_rdata_q <= s0_rdata_d;
            s1_rdata_q <= s1_rdata_d;
        end
    end

    // Valid drops in the completion cycle so downstream never sees a stale request.
    assign o_m_valid    = (state_q == ST_REQ) && !i_m_ready;
    assign o_m_reqtyp   = req_q.reqtyp;
    assign o_m_addr     = req_q.addr;
    assign o_m_size     = req_q.size;
    assign o_m_cachable = req_q.cachable;
    assign o_m_wdata    = req_q.wdata;

    assign o_s0_ready = s0_ready_q;
    assign o_s1_ready = s1_ready_q;
    assign o_s0_rdata = s0_rdata_q;
    assign o_s1_rdata = s1_rdata_q;

endmodule

// File: tb/tb_uni_arbiter.sv
// Randomised and directed bench for uni_arbiter against a transaction-level model of the arbiter.
module tb_uni_arbiter;
    localparam int   AW        = 32;
    localparam int   DW        = 128;
    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    logic          clk;
    logic          rst;
    logic          i_s0_valid, i_s0_reqtyp, i_s0_cachable;
    logic [AW-1:0] i_s0_addr;
    logic [1:0]    i_s0_size;
    logic [DW-1:0] i_s0_wdata;
    logic          o_s0_ready;
    logic [DW-1:0] o_s0_rdata;
    logic          i_s1_valid, i_s1_reqtyp, i_s1_cachable;
    logic [AW-1:0] i_s1_addr;
    logic [1:0]    i_s1_size;
    logic [DW-1:0] i_s1_wdata;
    logic          o_s1_ready;
    logic [DW-1:0] o_s1_rdata;
    logic          o_m_valid, o_m_reqtyp, o_m_cachable;
    logic [AW-1:0] o_m_addr;
    logic [1:0]    o_m_size;
    logic [DW-1:0] o_m_wdata;
    logic          i_m_ready;
    logic [DW-1:0] i_m_rdata;

    uni_arbiter #(.UNI_ADDR_WIDTH(AW), .UNI_DATA_WIDTH(DW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_s0_valid(i_s0_valid), .i_s0_reqtyp(i_s0_reqtyp), .i_s0_addr(i_s0_addr),
        .i_s0_size(i_s0_size), .i_s0_cachable(i_s0_cachable), .i_s0_wdata(i_s0_wdata),
        .o_s0_ready(o_s0_ready), .o_s0_rdata(o_s0_rdata),
        .i_s1_valid(i_s1_valid), .i_s1_reqtyp(i_s1_reqtyp), .i_s1_addr(i_s1_addr),
        .i_s1_size(i_s1_size), .i_s1_cachable(i_s1_cachable), .i_s1_wdata(i_s1_wdata),
        .o_s1_ready(o_s1_ready), .o_s1_rdata(o_s1_rdata),
        .o_m_valid(o_m_valid), .o_m_reqtyp(o_m_reqtyp), .o_m_addr(o_m_addr),
        .o_m_size(o_m_size), .o_m_cachable(o_m_cachable), .o_m_wdata(o_m_wdata),
        .i_m_ready(i_m_ready), .i_m_rdata(i_m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Transaction-level model: who owns the downstream port, which phase, what was latched.
    bit            m_busy, m_resp;
    int            m_owner, m_pref;
    logic          m_reqtyp, m_cach;
    logic [AW-1:0] m_addr;
    logic [1:0]    m_size;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata [2];
    logic          m_ready [2];
    int            gnt_log [$];

    bit auto_resp, stray_en, rand_en, draining;
    int resp_cnt;
    bit drop_pend [2];
    bit rm_done [2];

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic get_valid(input int n);
        return (n == 0) ? i_s0_valid : i_s1_valid;
    endfunction

    function automatic logic get_ready(input int n);
        return (n == 0) ? o_s0_ready : o_s1_ready;
    endfunction

    function automatic logic [DW-1:0] get_rdata(input int n);
        return (n == 0) ? o_s0_rdata : o_s1_rdata;
    endfunction

    task automatic drive_master(input int n, input logic v, input logic t, input logic [AW-1:0] a,
                                input logic [1:0] s, input logic c, input logic [DW-1:0] w);
        if (n == 0) begin
            i_s0_valid = v; i_s0_reqtyp = t; i_s0_addr = a; i_s0_size = s; i_s0_cachable = c; i_s0_wdata = w;
        end else begin
            i_s1_valid = v; i_s1_reqtyp = t; i_s1_addr = a; i_s1_size = s; i_s1_cachable = c; i_s1_wdata = w;
        end
    endtask

    task automatic new_req(input int n);
        drive_master(n, 1'b1, 1'($urandom_range(1, 0)), $urandom, 2'($urandom_range(3, 0)),
                     1'($urandom_range(1, 0)), {$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic model_reset();
        m_busy = 0; m_resp = 0; m_owner = 0; m_pref = 0;
        m_reqtyp = 0; m_addr = '0; m_size = '0; m_cach = 0; m_wdata = '0;
        for (int k = 0; k < 2; k++) begin
            m_rdata[k] = '0;
            m_ready[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        m_ready[0] = 1'b0;
        m_ready[1] = 1'b0;
        if (m_resp) begin
            m_resp = 0;
        end else if (m_busy) begin
            if (i_m_ready) begin
                m_rdata[m_owner] = i_m_rdata;
                m_ready[m_owner] = 1'b1;
                m_pref = 1 - m_owner;
                m_busy = 0;
                m_resp = 1;
            end
        end else begin
            // Offer the port to the preferred master first, then the other.
            for (int k = 0; k < 2; k++) begin
                int n;
                n = (m_pref + k) % 2;
                if (!m_busy && get_valid(n)) begin
                    m_busy = 1;
                    m_owner = n;
                    gnt_log.push_back(n);
                    if (n == 0) {m_reqtyp, m_addr, m_size, m_cach, m_wdata} = {i_s0_reqtyp, i_s0_addr, i_s0_size, i_s0_cachable, i_s0_wdata};
                    else        {m_reqtyp, m_addr, m_size, m_cach, m_wdata} = {i_s1_reqtyp, i_s1_addr, i_s1_size, i_s1_cachable, i_s1_wdata};
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("m_valid", DW'(o_m_valid), DW'(m_busy && !i_m_ready));
        chk("m_reqtyp", DW'(o_m_reqtyp), DW'(m_reqtyp));
        chk("m_addr", DW'(o_m_addr), DW'(m_addr));
        chk("m_size", DW'(o_m_size), DW'(m_size));
        chk("m_cachable", DW'(o_m_cachable), DW'(m_cach));
        chk("m_wdata", o_m_wdata, m_wdata);
        chk("s0_ready", DW'(o_s0_ready), DW'(m_ready[0]));
        chk("s1_ready", DW'(o_s1_ready), DW'(m_ready[1]));
        chk("s0_rdata", o_s0_rdata, m_rdata[0]);
        chk("s1_rdata", o_s1_rdata, m_rdata[1]);
    endtask

    task automatic resp_tick();
        i_m_ready = 1'b0;
        #1;
        if (o_m_valid) begin
            if (resp_cnt == 0) begin
                i_m_ready = 1'b1;
                i_m_rdata = {$urandom, $urandom, $urandom, $urandom};
                resp_cnt = $urandom_range(3, 1);
            end else begin
                resp_cnt--;
            end
        end else if (stray_en && $urandom_range(4, 0) == 0) begin
            i_m_ready = 1'b1;
            i_m_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic master_tick(input int n);
        bit own;
        own = (m_busy || m_resp) && (m_owner == n);
        if (rm_done[n]) begin
            rm_done[n] = 0;
            if (!draining && $urandom_range(1, 0) == 1) new_req(n);
            else drive_master(n, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        end else if (!get_valid(n)) begin
            if (!draining && $urandom_range(2, 0) == 0) new_req(n);
        end else if (!own && (draining || $urandom_range(9, 0) == 0)) begin
            drive_master(n, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        end
        if (get_ready(n)) rm_done[n] = 1;
    endtask

    // One clock: model advances on the edge, stimulus changes just after, outputs are compared at the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        for (int n = 0; n < 2; n++) begin
            if (drop_pend[n]) begin
                drive_master(n, 1'b0, 1'b0, '0, '0, 1'b0, '0);
                drop_pend[n] = 0;
            end
        end
        if (auto_resp) resp_tick();
        if (rand_en) begin
            master_tick(0);
            master_tick(1);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        drive_master(0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        drive_master(1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        i_m_ready = 1'b0;
        i_m_rdata = '0;
        resp_cnt = 1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic do_xact(input int n, input logic typ, input logic [AW-1:0] a, input logic [1:0] sz,
                           input logic c, input logic [DW-1:0] wd, input logic [DW-1:0] rd, input bit mutate);
        drive_master(n, 1'b1, typ, a, sz, c, wd);
        cycle();
        chk("xact_m_valid", DW'(o_m_valid), DW'(1'b1));
        chk("xact_m_addr", DW'(o_m_addr), DW'(a));
        chk("xact_m_size", DW'(o_m_size), DW'(sz));
        chk("xact_m_wdata", o_m_wdata, wd);
        if (mutate) drive_master(n, 1'b1, typ, a, sz, c, ~wd);
        cycle();
        chk("xact_wdata_held", o_m_wdata, wd);
        i_m_ready = 1'b1;
        i_m_rdata = rd;
        #1;
        chk("xact_valid_gated", DW'(o_m_valid), '0);
        cycle();
        i_m_ready = 1'b0;
        chk("xact_own_ready", DW'(get_ready(n)), DW'(1'b1));
        chk("xact_other_ready", DW'(get_ready(1 - n)), '0);
        chk("xact_own_rdata", get_rdata(n), rd);
        chk("xact_resp_valid", DW'(o_m_valid), '0);
        drop_pend[n] = 1;
        cycle();
        chk("xact_ready_once", DW'(get_ready(n)), '0);
    endtask

    localparam logic [DW-1:0] RD_A = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [DW-1:0] RD_B = 128'hCAFE0000BEEF1111DEAD2222F00D3333;
    localparam logic [DW-1:0] RD_C = 128'h0123456789ABCDEF0123456789ABCDEF;

    initial begin
        logic [AW-1:0] a0, a1;
        logic [AW-1:0] addr_log [$];
        bit pend0, pend1, prev_v, done;

        rst = 1'b1;
        auto_resp = 0; stray_en = 0; rand_en = 0; draining = 0;
        drop_pend[0] = 0; drop_pend[1] = 0; rm_done[0] = 0; rm_done[1] = 0;
        do_reset();
        chk("reset_m_valid", DW'(o_m_valid), '0);
        chk("reset_m_addr", DW'(o_m_addr), '0);
        chk("reset_s0_rdata", o_s0_rdata, '0);
        chk("reset_s1_ready", DW'(o_s1_ready), '0);

        // Single s0 cachable word read.
        do_xact(0, REQ_READ, 32'h8000_0000, 2'b10, 1'b1, '0, RD_A, 0);

        // Stray completion while idle must be ignored.
        i_m_ready = 1'b1;
        i_m_rdata = RD_C;
        cycle();
        i_m_ready = 1'b0;
        chk("stray_s0_ready", DW'(o_s0_ready), '0);
        chk("stray_s1_ready", DW'(o_s1_ready), '0);
        chk("stray_s0_rdata", o_s0_rdata, RD_A);
        cycle();
        chk("stray_after_valid", DW'(o_m_valid), '0);

        // s1 byte write; wdata wiggles after grant but the latched copy holds.
        do_xact(1, REQ_WRITE, 32'h1000_0003, 2'b00, 1'b0, 128'hAB, RD_C, 1);
        chk("wr_s0_rdata_kept", o_s0_rdata, RD_A);

        // Back-to-back reads on each master keep separate rdata.
        do_xact(0, REQ_READ, 32'h0000_0040, 2'b11, 1'b0, '0, RD_A, 0);
        do_xact(1, REQ_READ, 32'h0000_0080, 2'b01, 1'b1, '0, RD_B, 0);
        chk("sep_s0_rdata", o_s0_rdata, RD_A);
        chk("sep_s1_rdata", o_s1_rdata, RD_B);

        // Both masters continuously requesting: grants alternate starting at master 0.
        do_reset();
        gnt_log.delete();
        a0 = 32'h100; a1 = 32'h200;
        drive_master(0, 1'b1, REQ_READ, a0, 2'b10, 1'b0, '0);
        drive_master(1, 1'b1, REQ_READ, a1, 2'b10, 1'b0, '0);
        auto_resp = 1;
        pend0 = 0; pend1 = 0; prev_v = 0;
        for (int c = 0; c < 200 && addr_log.size() < 4; c++) begin
            cycle();
            if (o_m_valid && !prev_v) addr_log.push_back(o_m_addr);
            prev_v = o_m_valid;
            if (pend0) begin a0 = a0 + 32'h10; drive_master(0, 1'b1, REQ_READ, a0, 2'b10, 1'b0, '0); pend0 = 0; end
            if (pend1) begin a1 = a1 + 32'h10; drive_master(1, 1'b1, REQ_READ, a1, 2'b10, 1'b0, '0); pend1 = 0; end
            if (o_s0_ready) pend0 = 1;
            if (o_s1_ready) pend1 = 1;
        end
        chk("fair_grant_count", DW'(addr_log.size() >= 4), DW'(1'b1));
        if (addr_log.size() >= 4 && gnt_log.size() >= 4) begin
            chk("fair_addr0", DW'(addr_log[0]), DW'(32'h100));
            chk("fair_addr1", DW'(addr_log[1]), DW'(32'h200));
            chk("fair_addr2", DW'(addr_log[2]), DW'(32'h110));
            chk("fair_addr3", DW'(addr_log[3]), DW'(32'h210));
            chk("model_gnt0", DW'(gnt_log[0]), DW'(0));
            chk("model_gnt1", DW'(gnt_log[1]), DW'(1));
            chk("model_gnt2", DW'(gnt_log[2]), DW'(0));
            chk("model_gnt3", DW'(gnt_log[3]), DW'(1));
        end
        drive_master(1 - m_owner, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        done = 0;
        for (int c = 0; c < 50 && !done; c++) begin
            cycle();
            done = !m_busy && !m_resp;
        end
        chk("fair_drain", DW'(done), DW'(1'b1));
        drive_master(0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        drive_master(1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        auto_resp = 0;
        i_m_ready = 1'b0;
        cycle();

        // Reset while a request is outstanding; round-robin returns to master 0.
        do_xact(0, REQ_READ, 32'h40, 2'b10, 1'b0, '0, RD_B, 0);
        drive_master(0, 1'b1, REQ_READ, 32'h44, 2'b10, 1'b0, '0);
        cycle();
        chk("prerst_m_valid", DW'(o_m_valid), DW'(1'b1));
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_m_valid", DW'(o_m_valid), '0);
        chk("rst_m_addr", DW'(o_m_addr), '0);
        chk("rst_s0_rdata", o_s0_rdata, '0);
        drive_master(0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        cycle();
        cycle();
        rst = 1'b0;
        drive_master(0, 1'b1, REQ_READ, 32'h50, 2'b10, 1'b0, '0);
        drive_master(1, 1'b1, REQ_READ, 32'h60, 2'b10, 1'b0, '0);
        cycle();
        chk("rst_rr_ptr_addr", DW'(o_m_addr), DW'(32'h50));
        drive_master(1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        cycle();
        i_m_ready = 1'b1;
        i_m_rdata = RD_C;
        cycle();
        i_m_ready = 1'b0;
        chk("rst_s0_done", DW'(o_s0_ready), DW'(1'b1));
        drop_pend[0] = 1;
        cycle();
        do_xact(1, REQ_READ, 32'h70, 2'b10, 1'b1, '0, RD_A, 0);

        // Random traffic with stray completions, checked every cycle against the model.
        auto_resp = 1; stray_en = 1; rand_en = 1;
        for (int c = 0; c < 600; c++) cycle();
        draining = 1;
        done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            cycle();
            done = !i_s0_valid && !i_s1_valid && !m_busy && !m_resp;
        end
        chk("rand_drain", DW'(done), DW'(1'b1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uni_arbiter.md
Name: uni_arbiter

Overview:
- Two-master to one-slave arbiter for the unified memory request interface (uni_if).
- Sits directly upstream of the uni-to-AXI bridge. It merges instruction-fetch (master 0) and load/store (master 1) requests onto a single uni request stream.
- Round-robin grant; the winning request payload is latched at grant.
- Read data is returned to the granted master with a one-cycle registered ready pulse.

Parameters:
- UNI_ADDR_WIDTH, 32, request address width
- UNI_DATA_WIDTH, 128, wdata/rdata width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_sN_valid  in  1  master N request valid (N=0,1)
- i_sN_reqtyp  in  1  master N request type, `REQ_WRITE/`REQ_READ encoding
- i_sN_addr  in  UNI_ADDR_WIDTH  master N address
- i_sN_size  in  2  master N size (00 byte, 01 half, 10 word, 11 dword)
- i_sN_cachable  in  1  master N burst (line) request
- i_sN_wdata  in  UNI_DATA_WIDTH  master N write data
- o_sN_ready  out  1  completion pulse to master N
- o_sN_rdata  out  UNI_DATA_WIDTH  registered read data for master N
- o_m_valid  out  1  downstream request valid
- o_m_reqtyp, o_m_addr, o_m_size, o_m_cachable, o_m_wdata  out  (widths as above)  latched downstream payload
- i_m_ready  in  1  downstream completion pulse (registered, 1 cycle)
- i_m_rdata  in  UNI_DATA_WIDTH  downstream read data, valid in the i_m_ready cycle

Behaviour:
- Reset (i_rst=1, async) clears:
  - state to IDLE and rr_ptr to 0 (master 0 preferred)
  - all o_m_* payload registers to 0; o_sN_ready to 0; o_sN_rdata to 0
  - a reset mid-transaction abandons it; no ready is issued.
- States: IDLE, REQ, RESP. State and grant index gnt are registered.
- IDLE:
  - If exactly one i_sN_valid is high, grant that master.
  - If both are high, grant master rr_ptr.
  - On grant: latch that master's reqtyp/addr/size/cachable/wdata into the o_m_* registers, set gnt, go REQ.
  - If neither is high, stay in IDLE.
  - o_m_valid=0 in IDLE.
- REQ:
  - o_m_valid = ~i_m_ready (combinational gate). Valid drops in the completion cycle so the downstream state machine cannot restart on a stale valid.
  - Payload registers are held constant.
  - On i_m_ready: capture i_m_rdata into o_s{gnt}_rdata (for both reads and writes), set o_s{gnt}_ready=1 next cycle, rr_ptr <= ~gnt, go RESP.
- RESP:
  - o_s{gnt}_ready=1 for exactly this one cycle; the other master's ready stays 0.
  - o_m_valid=0. Go IDLE unconditionally.
- Master contract:
  - Hold valid and payload stable from assertion until the ready cycle, inclusive.
  - Valid seen in any cycle after the ready cycle is a new request.
  - The arbiter samples requests only in IDLE.
- Latency: request seen in IDLE at cycle t gives o_m_valid high at t+1. i_m_ready at cycle c gives o_sN_ready at c+1, and IDLE at c+2. Minimum request spacing per arbiter is 3 cycles plus the downstream latency.
- o_sN_rdata holds its value until that master's next completion; it is never overwritten by the other master's traffic.
- Fairness: with both masters continuously requesting, grants strictly alternate 0,1,0,1…
- i_m_ready outside REQ is ignored (no state change, no ready pulse).
- An i_sN_valid drop while not granted is allowed (request withdrawn); no effect.
- i_m_ready in REQ with o_m_valid gated low still completes the transaction.
- Widths: all payload passes through unmodified; no address or size translation.

Test Plan:
- Reset, then s0 read, addr=0x8000_0000, size=10, cachable=1 -> o_m_valid at t+1 with o_m_addr=0x8000_0000. i_m_ready with rdata=0x1122…FF at cycle c -> o_s0_ready=1 at c+1 only, o_s0_rdata=0x1122…FF, o_s1_ready=0 throughout.
- s0 and s1 assert valid in the same cycle, continuously for 4 transactions -> grant order 0,1,0,1; o_m_addr alternates between the two masters' addresses.
- s1 write, addr=0x1000_0003, size=00, wdata=0xAB; s1 changes wdata after grant but before ready -> o_m_wdata stays 0xAB; o_sN_ready pulses for s1 only.
- o_m_valid is 0 in the i_m_ready cycle and in the RESP cycle; a stray i_m_ready pulse while IDLE -> no state change, no o_sN_ready.
- Assert i_rst while in REQ -> o_m_valid=0 immediately, state IDLE, rr_ptr=0, no ready pulse; after release s1-only request -> granted normally.
- s0 read completes with rdata=A, then s1 read completes with rdata=B -> o_s0_rdata still A, o_s1_rdata=B.
